// File: rtl/mmc1_serial_loader_if.sv
// rtl/mmc1_serial_loader_if.sv - request, CPU and mapper bus bundle for the MMC1 serial loader
interface mmc1_serial_loader_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_reg;
  logic [4:0]  req_data;
  logic        req_rst_only;
  logic [15:0] cpu_ain;
  logic        cpu_write;
  logic [7:0]  cpu_din;
  logic [15:0] mmc_ain;
  logic        mmc_write;
  logic [7:0]  mmc_din;
  logic        busy;
  logic        cpu_stall;
  logic        cpu_conflict;
  logic        done_pulse;
  logic [3:0]  fifo_count;

  modport master (
    output req_valid, req_reg, req_data, req_rst_only, cpu_ain, cpu_write, cpu_din,
    input  req_ready, mmc_ain, mmc_write, mmc_din, busy, cpu_stall, cpu_conflict,
           done_pulse, fifo_count
  );

  modport slave (
    input  req_valid, req_reg, req_data, req_rst_only, cpu_ain, cpu_write, cpu_din,
    output req_ready, mmc_ain, mmc_write, mmc_din, busy, cpu_stall, cpu_conflict,
           done_pulse, fifo_count
  );
endinterface

// File: rtl/mmc1_serial_loader.sv
// rtl/mmc1_serial_loader.sv - turns queued MMC1 register writes into the 5-write serial sequence
module mmc1_serial_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CE     = 1
) (
  input logic clk,
  input logic reset_n,
  input logic ce,
  mmc1_serial_loader_if.slave bus
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int GCW = $clog2(GAP_CE + 1);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_GAP, S_BIT} state_t;

  // Queue entry layout: {rst_only, reg[1:0], data[4:0]}
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [3:0]     count_q;

  state_t         state_q;
  logic [2:0]     idx_q;
  logic [GCW-1:0] gap_q;
  logic           done_q;
  logic           conflict_q;

  logic           full_w, empty_w, push_w, pop_w, gap_last_w, stall_w;
  logic [7:0]     head_w;
  logic           head_rst_only_w;
  logic [1:0]     head_reg_w;
  logic [4:0]     head_data_w;

  assign full_w          = (count_q == 4'(FIFO_DEPTH));
  assign empty_w         = (count_q == 4'd0);
  assign bus.req_ready   = reset_n && !full_w;
  assign push_w          = bus.req_valid && bus.req_ready;
  assign head_w          = mem_q[rd_ptr_q];
  assign head_rst_only_w = head_w[7];
  assign head_reg_w      = head_w[6:5];
  assign head_data_w     = head_w[4:0];
  assign stall_w         = (state_q != S_IDLE);
  assign gap_last_w      = (gap_q == GCW'(GAP_CE - 1));

  // Completion is folded into the final GAP period's exit; that ce pops the head.
  assign pop_w = ce && (state_q == S_GAP) && gap_last_w && (head_rst_only_w || idx_q == 3'd5);

  // Queue storage; not reset because the count and pointers define validity.
  always_ff @(posedge clk) begin
    if (push_w) begin
      mem_q[wr_ptr_q] <= {bus.req_rst_only, bus.req_reg, bus.req_data};
    end
  end

  // Queue pointers and occupancy; pushes are accepted regardless of ce.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_w, pop_w})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sequencer: one state per ce period, plus the registered done/conflict pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      gap_q      <= '0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      done_q     <= pop_w;
      conflict_q <= ce && stall_w && bus.cpu_write && bus.cpu_ain[15];
      if (ce) begin
        case (state_q)
          S_IDLE: begin
            // A CPU write on this ce keeps the bus; the claim is retried next ce.
            if (!empty_w && !bus.cpu_write) state_q <= S_RST;
          end
          S_RST: begin
            idx_q   <= 3'd0;
            gap_q   <= '0;
            state_q <= S_GAP;
          end
          S_GAP: begin
            if (gap_last_w) begin
              if (head_rst_only_w || idx_q == 3'd5) state_q <= S_IDLE;
              else                                  state_q <= S_BIT;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          S_BIT: begin
            idx_q   <= idx_q + 3'd1;
            gap_q   <= '0;
            state_q <= S_GAP;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Mapper bus mux: CPU passthrough in IDLE, sequencer-generated writes otherwise.
  always_comb begin
    bus.mmc_ain   = bus.cpu_ain;
    bus.mmc_write = bus.cpu_write;
    bus.mmc_din   = bus.cpu_din;
    case (state_q)
      S_RST: begin
        bus.mmc_ain   = 16'h8000;
        bus.mmc_din   = 8'h80;
        bus.mmc_write = 1'b1;
      end
      S_GAP: begin
        // Address holds whatever the preceding write presented.
        bus.mmc_ain   = (idx_q == 3'd0) ? 16'h8000 : {1'b1, head_reg_w, 13'h0};
        bus.mmc_din   = 8'h00;
        bus.mmc_write = 1'b0;
      end
      S_BIT: begin
        bus.mmc_ain   = {1'b1, head_reg_w, 13'h0};
        bus.mmc_din   = {7'b0, head_data_w[idx_q]};
        bus.mmc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy         = !empty_w || stall_w;
  assign bus.cpu_stall    = stall_w;
  assign bus.cpu_conflict = conflict_q;
  assign bus.done_pulse   = done_q;
  assign bus.fifo_count   = count_q;

endmodule

// File: doc/mmc1_serial_loader.md
Name: mmc1_serial_loader

Overview:
- Sequences parallel MMC1 register writes into the 5-write serial protocol the MMC1 mapper requires.
- Sits between the CPU-side PRG write bus and the MMC1 mapper's prg_ain/prg_write/prg_din inputs.
- Used by debug, savestate fix-up and test harnesses to program control, chr_bank_0, chr_bank_1 or prg_bank atomically, without CPU involvement.
- Arbitrates the mapper write bus between the CPU (passthrough) and its own sequencer.

Parameters:
- FIFO_DEPTH, 4: number of pending register-write requests; power of two, range 2..8.
- GAP_CE, 1: idle ce periods (prg_write=0) inserted after every generated write; minimum 1, so the mapper's back-to-back write guard clears.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- ce  in  1  M2 strobe; all sequencer state advances only on clk edges with ce=1
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept a request
- req_reg  in  2  target register: 0 control, 1 chr_bank_0, 2 chr_bank_1, 3 prg_bank
- req_data  in  5  register value
- req_rst_only  in  1  1 = issue the shift-reset write only; req_reg and req_data are ignored
- cpu_ain  in  16  CPU address
- cpu_write  in  1  CPU write strobe
- cpu_din  in  8  CPU write data
- mmc_ain  out  16  address to mapper
- mmc_write  out  1  write strobe to mapper
- mmc_din  out  8  data to mapper
- busy  out  1  FIFO non-empty or sequencer not IDLE
- cpu_stall  out  1  sequencer owns the mapper bus
- cpu_conflict  out  1  one-clk pulse: CPU wrote to $8000-$FFFF while stalled; that write was dropped
- done_pulse  out  1  one-clk pulse when a request completes
- fifo_count  out  4  entries currently queued

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - FIFO cleared, FSM to IDLE.
  - Outputs: req_ready=0 during reset, busy=0, cpu_stall=0, cpu_conflict=0, done_pulse=0, fifo_count=0, mmc_* = passthrough.
  - Reset mid-sequence abandons that sequence; the mapper shift register may be left partial. This is safe because every sequence begins with a reset write.
- FIFO:
  - Push on any clk with req_valid && req_ready; req_ready = !full.
  - Push while full is ignored.
  - Pop happens only at request completion. Push and pop on the same clk both take effect; count is unchanged.
- mmc_* outputs are combinational from FSM state and the FIFO head. The state register updates on ce, so each state is presented for exactly one ce period, and the mapper samples it on the next ce.
- FSM states:
  - IDLE: passthrough (mmc_* = cpu_*), cpu_stall=0. On ce with FIFO non-empty and cpu_write=0, go to RST. If cpu_write=1, stay in IDLE; the CPU write passes through and the claim is retried on the next ce.
  - RST: mmc_ain=16'h8000, mmc_din=8'h80, mmc_write=1. Then go to GAP with bit index 0.
  - GAP: mmc_write=0, mmc_ain holds its last value, mmc_din=0. Stay for GAP_CE ce periods. Then:
    - if the entry is rst_only, or 5 bits have been sent: go to FIN;
    - else: go to BIT.
  - BIT: mmc_ain={1'b1, reg, 13'h0}, mmc_din={7'b0, data[idx]} (LSB first), mmc_write=1. Increment idx, then go to GAP.
  - FIN: done is evaluated on the same ce as the last GAP period's exit, with no extra ce period. Pop FIFO, done_pulse=1 for one clk, go to IDLE.
- Fairness: at least one ce in IDLE between consecutive requests, so the CPU gets a bus slot each time.
- Latency: done_pulse occurs (1+GAP_CE)*6 ce edges after the claiming ce for a full request, and 1+GAP_CE for rst_only. With GAP_CE=1 that is 12 and 2.
- Stall: cpu_stall=1 in RST, GAP and BIT. During stall, a cpu_write with cpu_ain[15]=1 on a ce raises cpu_conflict for one clk and the write is not forwarded. CPU writes below $8000 are also not forwarded while stalled, and no conflict is flagged for them.
- busy: = (fifo_count!=0) || state!=IDLE.
- ce=0 clocks: state, outputs and counters are frozen; pushes are still accepted.

Test Plan:
- reset_n=0 for 3 clk, then push {reg=3, data=5'b10110} with ce every 3rd clk:
  - mapper sees writes ($8000,80), ($E000,00), ($E000,01), ($E000,01), ($E000,00), ($E000,01), each separated by one idle ce;
  - MMC1 prg_bank becomes 5'b10110;
  - done_pulse arrives 12 ce after the claim.
- Push 4 requests back-to-back:
  - fifo_count reaches 4 and req_ready=0;
  - a 5th push is ignored;
  - completions occur in order with ≥1 IDLE ce between them;
  - final MMC1 register values match.
- Hold cpu_write=1 on the would-be claim ce:
  - CPU write passes through;
  - claim happens on the next ce with cpu_write=0.
  - CPU write to $A000 mid-sequence: cpu_conflict pulses and the mapper receives no extra write.
- Assert reset_n=0 after the 3rd BIT write, then push {reg=0, data=5'b01111}:
  - control=5'b01111, proving the leading reset write resyncs the partial shift.
- Push rst_only:
  - exactly one ($8000,80) write;
  - done_pulse after 2 ce;
  - control[3:2] is OR'd to 2'b11.
- GAP_CE=3 build:
  - 3 idle ce after each write;
  - done_pulse 24 ce after the claim.
